// File: rtl/cruise_control_ctrl.sv
// cruise_control_ctrl: parametrised cruise-control FSM with tick prescaler, edge-detected buttons and resume memory
// Ports: clk, reset (async, active-high); throttle/brake pedal levels; set/resume/cancel/accel/coast buttons;
// current_speed, cruise_set_speed, cruise_active, current_state, last_state, last_set_speed registered outputs.
module cruise_control_ctrl #(
  parameter int SPEED_W       = 8,
  parameter int MIN_SET_SPEED = 40,
  parameter int MAX_SPEED     = 200,
  parameter int ACCEL_STEP    = 2,
  parameter int COAST_STEP    = 1,
  parameter int BRAKE_STEP    = 2,
  parameter int UPDATE_DIV    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               throttle,
  input  logic               brake,
  input  logic               set,
  input  logic               resume,
  input  logic               cancel,
  input  logic               accel,
  input  logic               coast,
  output logic [SPEED_W-1:0] current_speed,
  output logic [SPEED_W-1:0] cruise_set_speed,
  output logic               cruise_active,
  output logic [2:0]         current_state,
  output logic [2:0]         last_state,
  output logic [SPEED_W-1:0] last_set_speed
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MAN_ACCEL = 3'd1,
    MAN_COAST = 3'd2,
    CRUISE    = 3'd3,
    BRAKE     = 3'd4,
    CANCELLED = 3'd5
  } state_t;
  localparam int CW  = UPDATE_DIV > 1 ? $clog2(UPDATE_DIV) : 1;
  localparam int SW1 = SPEED_W + 1;
  localparam logic [CW-1:0]      CNT_MAX = CW'(UPDATE_DIV - 1);
  localparam logic [SPEED_W-1:0] MIN_V   = SPEED_W'(MIN_SET_SPEED);
  localparam logic [SPEED_W-1:0] MAX_V   = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] CST_V   = SPEED_W'(COAST_STEP);
  localparam logic [SPEED_W-1:0] BRK_V   = SPEED_W'(BRAKE_STEP);
  localparam logic [SW1-1:0]     ACC_V   = SW1'(ACCEL_STEP);
  state_t             state_q, state_d;
  logic [2:0]         last_state_q;
  logic [SPEED_W-1:0] speed_q, speed_d, set_q, set_d, last_set_q, last_set_d, tgt;
  logic               active_q, active_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [4:0]         btn, btn_q, pend, pend_q, pend_d;
  logic               tick, can_set, can_resume;
  logic [SW1-1:0]     up;
  logic [SPEED_W-1:0] speed_acc, speed_cst, speed_brk, speed_trk, set_clamp, set_adj;
  // button order: {coast, accel, cancel, resume, set}
  assign btn  = {coast, accel, cancel, resume, set};
  assign tick = cnt_q == CNT_MAX;
  // an edge arriving on the tick cycle itself is consumed by that tick
  assign pend   = pend_q | (btn & ~btn_q);
  assign pend_d = tick ? '0 : pend;
  assign cnt_d  = tick ? '0 : cnt_q + 1'b1;
  // one spare bit on the add so the ceiling compare cannot wrap
  assign up        = {1'b0, speed_q} + ACC_V;
  assign speed_acc = up > SW1'(MAX_SPEED) ? MAX_V : up[SPEED_W-1:0];
  assign speed_cst = speed_q > CST_V ? speed_q - CST_V : '0;
  assign speed_brk = speed_q > BRK_V ? speed_q - BRK_V : '0;
  assign speed_trk = speed_q < set_q ? speed_q + 1'b1 : speed_q > set_q ? speed_q - 1'b1 : speed_q;
  assign set_clamp = speed_q > MAX_V ? MAX_V : speed_q;
  // simultaneous accel and coast cancel each other out
  assign set_adj = pend[3] == pend[4] ? set_q :
                   pend[3] ? (set_q >= MAX_V ? MAX_V : set_q + 1'b1) :
                   (set_q <= MIN_V ? MIN_V : set_q - 1'b1);
  assign can_set    = speed_q >= MIN_V;
  assign can_resume = pend[1] && can_set && last_set_q != '0;
  always_comb begin
    state_d = IDLE;
    speed_d = speed_q;
    tgt     = last_set_q;
    case (state_q)
      IDLE: state_d = throttle ? MAN_ACCEL : IDLE;
      MAN_ACCEL: begin
        state_d = pend[0] && can_set ? CRUISE : throttle ? MAN_ACCEL : MAN_COAST;
        speed_d = throttle ? speed_acc : speed_q;
        tgt     = set_clamp;
      end
      MAN_COAST: begin
        state_d = throttle ? MAN_ACCEL : pend[0] && can_set ? CRUISE : speed_q == '0 ? IDLE : MAN_COAST;
        speed_d = speed_cst;
        tgt     = set_clamp;
      end
      CRUISE: begin
        state_d = brake ? BRAKE : pend[2] ? CANCELLED : CRUISE;
        speed_d = throttle ? speed_acc : speed_trk;
        tgt     = set_adj;
      end
      BRAKE: begin
        state_d = speed_q == '0 ? IDLE : !brake && can_resume ? CRUISE : BRAKE;
        speed_d = speed_brk;
      end
      CANCELLED: begin
        state_d = speed_q == '0 ? IDLE : can_resume ? CRUISE : CANCELLED;
        speed_d = throttle ? speed_q : speed_cst;
      end
      default: state_d = IDLE;
    endcase
  end
  assign set_d      = state_d == CRUISE ? tgt : '0;
  assign last_set_d = state_d == CRUISE ? tgt : state_d == IDLE ? '0 : last_set_q;
  assign active_d   = state_d == CRUISE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      btn_q        <= '0;
      pend_q       <= '0;
      state_q      <= IDLE;
      last_state_q <= '0;
      speed_q      <= '0;
      set_q        <= '0;
      last_set_q   <= '0;
      active_q     <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      btn_q  <= btn;
      pend_q <= pend_d;
      if (tick) begin
        state_q      <= state_d;
        last_state_q <= state_q;
        speed_q      <= speed_d;
        set_q        <= set_d;
        last_set_q   <= last_set_d;
        active_q     <= active_d;
      end
    end
  end
  assign current_speed    = speed_q;
  assign cruise_set_speed = set_q;
  assign cruise_active    = active_q;
  assign current_state    = state_q;
  assign last_state       = last_state_q;
  assign last_set_speed   = last_set_q;
endmodule
